llc_evict_way_update: RTL and testbench

// - Downstream of the LLC way-lookup stage; consumes each lookup result (set, chosen way, hit/evict).
// - On replacement it advances that set's round-robin eviction pointer and writes it back to the per-set evict-way RAM.
// - Holds up to 2 pending writes, coalescing back-to-back updates to the same set.
// - Forwards pending pointer values to the tag/state read stage, so a same-set lookup never reads a stale RAM value.
// - After reset, walks every set and writes pointer 0 before accepting traffic.

---
 rtl/llc_evict_way_update.sv | 158 +++++++++++++++
 tb/tb_llc_evict_way_update.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_evict_way_update.sv
// Round-robin eviction-pointer updater for the LLC: a 2-entry coalescing write queue in front of the
// per-set evict-way RAM, with forwarding and a post-reset RAM walk. Optional stats: LLC_EVICT_UPDATE_STATS_EN.
module llc_evict_way_update #(
    parameter int SET_BITS = 8,
    parameter int WAY_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SET_BITS-1:0] in_set,
    input  logic [WAY_BITS-1:0] in_way,
    input  logic                in_update,
    input  logic                in_evict,
    output logic                wr_en,
    input  logic                wr_ready,
    output logic [SET_BITS-1:0] wr_set,
    output logic [WAY_BITS-1:0] wr_data,
    input  logic [SET_BITS-1:0] fwd_set,
    output logic                fwd_hit,
    output logic [WAY_BITS-1:0] fwd_way,
    output logic                flush_done
`ifdef LLC_EVICT_UPDATE_STATS_EN
    ,
    output logic [31:0]         evict_cnt,
    output logic [31:0]         fill_cnt
`endif
);

    typedef enum logic {ST_FLUSH, ST_RUN} state_t;

    state_t              r_state;
    logic [SET_BITS-1:0] r_flush_set;
    logic [SET_BITS-1:0] r_q_set [2];
    logic [WAY_BITS-1:0] r_q_ptr [2];
    logic [1:0]          r_count;
    logic                r_in_ready;
    logic                r_flush_done;

    logic                w_accept;
    logic                w_push_upd;
    logic                w_pop;
    logic                w_coalesce;
    logic                w_coal_slot;
    logic [SET_BITS-1:0] w_young_set;
    logic [WAY_BITS-1:0] w_new_ptr;
    logic [SET_BITS-1:0] w_q_set_next [2];
    logic [WAY_BITS-1:0] w_q_ptr_next [2];
    logic [1:0]          w_count_next;
    logic [1:0]          w_fwd_match;

    assign w_accept    = in_valid && r_in_ready;
    assign w_push_upd  = w_accept && in_update;
    assign w_pop       = (r_state == ST_RUN) && (r_count != 2'd0) && wr_ready;
    assign w_new_ptr   = in_way + WAY_BITS'(1);
    assign w_young_set = (r_count == 2'd2) ? r_q_set[1] : r_q_set[0];

    // Never merge into a head that leaves this cycle; its write is already committed to the RAM.
    assign w_coalesce  = (r_count != 2'd0) && (w_young_set == in_set) &&
                         !((r_count == 2'd1) && w_pop);
    // Youngest slot after an optional shift caused by the pop.
    assign w_coal_slot = (r_count == 2'd2) && !w_pop;

    always_comb begin
        w_q_set_next = r_q_set;
        w_q_ptr_next = r_q_ptr;
        w_count_next = r_count;
        if (w_pop) begin
            w_q_set_next[0] = r_q_set[1];
            w_q_ptr_next[0] = r_q_ptr[1];
            w_count_next    = r_count - 2'd1;
        end
        if (w_push_upd) begin
            if (w_coalesce) begin
                w_q_ptr_next[w_coal_slot] = w_new_ptr;
            end else begin
                w_q_set_next[w_count_next[0]] = in_set;
                w_q_ptr_next[w_count_next[0]] = w_new_ptr;
                w_count_next                  = w_count_next + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FLUSH;
            r_flush_set  <= '0;
            r_count      <= 2'd0;
            r_in_ready   <= 1'b0;
            r_flush_done <= 1'b0;
            r_q_set[0]   <= '0;
            r_q_set[1]   <= '0;
            r_q_ptr[0]   <= '0;
            r_q_ptr[1]   <= '0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    if (wr_ready) begin
                        r_flush_set <= r_flush_set + SET_BITS'(1);
                        if (r_flush_set == {SET_BITS{1'b1}}) begin
                            r_state      <= ST_RUN;
                            r_flush_done <= 1'b1;
                            r_in_ready   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_q_set    <= w_q_set_next;
                    r_q_ptr    <= w_q_ptr_next;
                    r_count    <= w_count_next;
                    r_in_ready <= (w_count_next < 2'd2);
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd_match[gi] = (r_state == ST_RUN) && (r_count > 2'(gi)) &&
                                     (r_q_set[gi] == fwd_set);
        end
    endgenerate

    assign fwd_hit    = |w_fwd_match;
    assign fwd_way    = w_fwd_match[1] ? r_q_ptr[1] : r_q_ptr[0];

    assign in_ready   = r_in_ready;
    assign flush_done = r_flush_done;
    assign wr_en      = (r_state == ST_FLUSH) || (r_count != 2'd0);
    assign wr_set     = (r_state == ST_FLUSH) ? r_flush_set : r_q_set[0];
    assign wr_data    = (r_state == ST_FLUSH) ? '0 : r_q_ptr[0];

`ifdef LLC_EVICT_UPDATE_STATS_EN
    logic [31:0] r_evict_cnt;
    logic [31:0] r_fill_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_evict_cnt <= '0;
            r_fill_cnt  <= '0;
        end else if (w_push_upd) begin
            if (in_evict) begin
                if (r_evict_cnt != 32'hFFFF_FFFF) r_evict_cnt <= r_evict_cnt + 32'd1;
            end else begin
                if (r_fill_cnt != 32'hFFFF_FFFF) r_fill_cnt <= r_fill_cnt + 32'd1;
            end
        end
    end

    assign evict_cnt = r_evict_cnt;
    assign fill_cnt  = r_fill_cnt;
`else
    logic w_unused_evict;
    assign w_unused_evict = in_evict;
`endif

endmodule

// File: tb/tb_llc_evict_way_update.sv
// Directed bench for llc_evict_way_update: expected RAM writes are queued at stimulus time and
// popped by a write monitor; other observations use immediate assertions inline.
`timescale 1ns/1ps
module tb_llc_evict_way_update;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_set;
    logic [3:0] in_way;
    logic       in_update;
    logic       in_evict;
    logic       wr_en;
    logic       wr_ready;
    logic [7:0] wr_set;
    logic [3:0] wr_data;
    logic [7:0] fwd_set;
    logic       fwd_hit;
    logic [3:0] fwd_way;
    logic       flush_done;
`ifdef LLC_EVICT_UPDATE_STATS_EN
    logic [31:0] evict_cnt;
    logic [31:0] fill_cnt;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic [3:0] d;
    } wr_t;

    wr_t sb[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    bit  mon_en   = 1'b0;

    always #5 clk = ~clk;

    llc_evict_way_update #(.SET_BITS(8), .WAY_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_set     (in_set),
        .in_way     (in_way),
        .in_update  (in_update),
        .in_evict   (in_evict),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_set     (wr_set),
        .wr_data    (wr_data),
        .fwd_set    (fwd_set),
        .fwd_hit    (fwd_hit),
        .fwd_way    (fwd_way),
        .flush_done (flush_done)
`ifdef LLC_EVICT_UPDATE_STATS_EN
        ,
        .evict_cnt  (evict_cnt),
        .fill_cnt   (fill_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] s, input logic [3:0] w, input logic upd, input logic ev);
        in_valid  = 1'b1;
        in_set    = s;
        in_way    = w;
        in_update = upd;
        in_evict  = ev;
    endtask

    task automatic load_flush();
        for (int i = 0; i < 256; i++) sb.push_back(wr_t'{s: 8'(i), d: 4'd0});
    endtask

    task automatic wait_flush(input string tag);
        int lo = 0;
        int guard = 0;
        bit rdy_seen = 1'b0;
        while (!flush_done && guard < 400) begin
            at_neg();
            guard++;
            if (!flush_done) begin
                lo++;
                if (in_ready) rdy_seen = 1'b1;
            end
        end
        check({tag, "_cycles"}, 32'(lo), 32'd256);
        check({tag, "_in_ready_low"}, 32'(rdy_seen), 32'd0);
        check({tag, "_done"}, 32'(flush_done), 32'd1);
        check({tag, "_all_written"}, 32'(sb.size()), 32'd0);
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    // Every RAM write that commits at the next rising edge is compared against the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (mon_en && !rst && wr_en && wr_ready) begin
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                $display("write set=%0d data=%0d (expect set=%0d data=%0d)", wr_set, wr_data, e.s, e.d);
                check("wr_set", 32'(wr_set), 32'(e.s));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        rst = 1'b1; in_valid = 1'b0; in_set = '0; in_way = '0;
        in_update = 1'b0; in_evict = 1'b0; wr_ready = 1'b0; fwd_set = '0;

        // Reset state
        tick();
        at_neg();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd1);
        check("rst_wr_set", 32'(wr_set), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);

        // Initial RAM walk
        load_flush();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        wr_ready = 1'b1;
        wait_flush("flush1");

        // Wrap of way 15 to pointer 0
        tick();
        drive(8'd5, 4'd15, 1'b1, 1'b1);
        sb.push_back(wr_t'{s: 8'd5, d: 4'd0});
        tick();
        in_valid = 1'b0;
        at_neg();
        check("wrap_wr_en", 32'(wr_en), 32'd1);
        fwd_set = 8'd5;
        #1;
        check("wrap_fwd_hit", 32'(fwd_hit), 32'd1);
        check("wrap_fwd_way", 32'(fwd_way), 32'd0);
        tick();
        wr_ready = 1'b0;
        at_neg();
        check("idle_wr_en", 32'(wr_en), 32'd0);

        // Coalesce two updates to set 3 while the RAM stalls
        tick();
        drive(8'd3, 4'd2, 1'b1, 1'b0);
        tick();
        drive(8'd3, 4'd7, 1'b1, 1'b0);
        sb.push_back(wr_t'{s: 8'd3, d: 4'd8});
        tick();
        in_valid = 1'b0;
        at_neg();
        fwd_set = 8'd3;
        #1;
        check("coal_wr_set", 32'(wr_set), 32'd3);
        check("coal_wr_data", 32'(wr_data), 32'd8);
        check("coal_in_ready", 32'(in_ready), 32'd1);
        check("coal_fwd_hit", 32'(fwd_hit), 32'd1);
        check("coal_fwd_way", 32'(fwd_way), 32'd8);
        tick();
        at_neg();
        check("stall_stable_set", 32'(wr_set), 32'd3);
        check("stall_stable_data", 32'(wr_data), 32'd8);
        tick();
        wr_ready = 1'b1;
        tick();
        wr_ready = 1'b0;

        // Fill the queue, hold a third input, then drain in order
        drive(8'd1, 4'd0, 1'b1, 1'b0);
        sb.push_back(wr_t'{s: 8'd1, d: 4'd1});
        tick();
        drive(8'd2, 4'd1, 1'b1, 1'b0);
        sb.push_back(wr_t'{s: 8'd2, d: 4'd2});
        tick();
        drive(8'd4, 4'd3, 1'b1, 1'b0);
        sb.push_back(wr_t'{s: 8'd4, d: 4'd4});
        at_neg();
        check("full_in_ready", 32'(in_ready), 32'd0);
        fwd_set = 8'd1;
        #1;
        check("full_fwd1_hit", 32'(fwd_hit), 32'd1);
        check("full_fwd1_way", 32'(fwd_way), 32'd1);
        fwd_set = 8'd2;
        #1;
        check("full_fwd2_way", 32'(fwd_way), 32'd2);
        tick();
        at_neg();
        check("held_in_ready", 32'(in_ready), 32'd0);
        check("held_wr_set", 32'(wr_set), 32'd1);
        tick();
        wr_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 10) begin
            tick();
            g++;
        end
        check("held_wait_timeout", 32'(g >= 10), 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        at_neg();
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_wr_en", 32'(wr_en), 32'd0);

        // Tag hit: no update
        tick();
        drive(8'd9, 4'd5, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        at_neg();
        fwd_set = 8'd9;
        #1;
        check("hit_wr_en", 32'(wr_en), 32'd0);
        check("hit_fwd_hit", 32'(fwd_hit), 32'd0);

        // Same set as a head being popped: new entry, not a merge
        tick();
        drive(8'd6, 4'd0, 1'b1, 1'b0);
        sb.push_back(wr_t'{s: 8'd6, d: 4'd1});
        tick();
        drive(8'd6, 4'd1, 1'b1, 1'b0);
        sb.push_back(wr_t'{s: 8'd6, d: 4'd2});
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        at_neg();
        check("popmerge_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with two entries pending
        tick();
        wr_ready = 1'b0;
        drive(8'd10, 4'd0, 1'b1, 1'b1);
        tick();
        drive(8'd11, 4'd0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        at_neg();
        check("pend_in_ready", 32'(in_ready), 32'd0);
        check("pend_wr_set", 32'(wr_set), 32'd10);
`ifdef LLC_EVICT_UPDATE_STATS_EN
        check("stats_evict", evict_cnt, 32'd2);
        check("stats_fill", fill_cnt, 32'd8);
`endif
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        at_neg();
        fwd_set = 8'd10;
        #1;
        check("rst2_in_ready", 32'(in_ready), 32'd0);
        check("rst2_flush_done", 32'(flush_done), 32'd0);
        check("rst2_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst2_wr_set", 32'(wr_set), 32'd0);
        check("rst2_wr_data", 32'(wr_data), 32'd0);
`ifdef LLC_EVICT_UPDATE_STATS_EN
        check("rst2_evict_cnt", evict_cnt, 32'd0);
        check("rst2_fill_cnt", fill_cnt, 32'd0);
`endif
        load_flush();
        tick();
        wr_ready = 1'b1;
        wait_flush("flush2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
